// File: rtl/intf_array_rr_arbiter_if.sv
// Valid/ready stream interface with packet framing, used on both sides of the arbiter.
interface stream_if #(
  parameter int unsigned W = 8
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;
  logic         last;

  modport source (output valid, output data, output last, input ready);
  modport sink   (input valid, input data, input last, output ready);
endinterface

// File: rtl/intf_array_rr_arbiter.sv
// N-to-1 round-robin stream arbiter with packet lock and a one-entry registered output stage.
module intf_array_rr_arbiter #(
  parameter int unsigned  N   = 4,
  parameter int unsigned  W   = 8,
  localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  stream_if.sink         in_ifs [N-1:0],
  stream_if.source       out_if,
  output logic [IDW-1:0] out_id,
  output logic           locked
);

  typedef enum logic {StIdle, StLocked} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   in_valid, in_last, in_ready;
  logic [W-1:0]   in_data [N];
  logic [IDW-1:0] ptr_q, ptr_d, lock_ch_q, lock_ch_d;
  logic [IDW-1:0] sel, cand;
  logic           sel_valid, load, accept;
  logic           valid_q, valid_d, last_q, last_d;
  logic [W-1:0]   data_q, data_d;
  logic [IDW-1:0] id_q, id_d;

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign in_valid[g]     = in_ifs[g].valid;
    assign in_last[g]      = in_ifs[g].last;
    assign in_data[g]      = in_ifs[g].data;
    assign in_ifs[g].ready = in_ready[g];
  end

  // Register is empty or draining this cycle.
  assign load = !valid_q || out_if.ready;

  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    cand      = '0;
    if (state_q == StLocked) begin
      sel       = lock_ch_q;
      sel_valid = in_valid[lock_ch_q];
    end else begin
      // Nearest valid channel after ptr wins.
      for (int unsigned k = 1; k <= N; k++) begin
        cand = IDW'((32'(ptr_q) + k) % N);
        if (!sel_valid && in_valid[cand]) begin
          sel       = cand;
          sel_valid = 1'b1;
        end
      end
    end
  end

  // rst_n gating keeps every ready low while reset is held.
  assign accept = rst_n && load && sel_valid;

  always_comb begin
    in_ready = '0;
    if (accept) in_ready[sel] = 1'b1;
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (load) valid_d = accept;
    if (accept) begin
      data_d = in_data[sel];
      last_d = in_last[sel];
      id_d   = sel;
      ptr_d  = sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      id_q    <= '0;
      ptr_q   <= IDW'(N - 1);
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      lock_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    unique case (state_q)
      StIdle: begin
        if (accept && !in_last[sel]) begin
          state_d   = StLocked;
          lock_ch_d = sel;
        end
      end
      StLocked: begin
        if (accept && in_last[sel]) state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    locked = (state_q == StLocked);
    out_id = id_q;
  end

  assign out_if.valid = valid_q;
  assign out_if.data  = data_q;
  assign out_if.last  = last_q;

endmodule

// File: tb/tb_intf_array_rr_arbiter.sv
// Scoreboard bench: queued producers per channel, expected beats checked as they leave the DUT.
module tb_intf_array_rr_arbiter;
  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_if #(.W(W))  in_ifs [N-1:0] ();
  stream_if #(.W(W))  out_if ();
  stream_if #(.W(16)) in1_ifs [0:0] ();
  stream_if #(.W(16)) out1_if ();

  logic [1:0]   out_id;
  logic         locked;
  logic [0:0]   out1_id;
  logic         locked1;

  logic [N-1:0] in_valid, in_last, in_ready;
  logic [W-1:0] in_data [N];
  logic         out_ready;
  logic         v1, l1;
  logic [15:0]  d1;

  for (genvar g = 0; g < N; g++) begin : g_bind
    assign in_ifs[g].valid = in_valid[g];
    assign in_ifs[g].data  = in_data[g];
    assign in_ifs[g].last  = in_last[g];
    assign in_ready[g]     = in_ifs[g].ready;
  end
  assign out_if.ready     = out_ready;
  assign in1_ifs[0].valid = v1;
  assign in1_ifs[0].data  = d1;
  assign in1_ifs[0].last  = l1;
  assign out1_if.ready    = 1'b1;

  intf_array_rr_arbiter #(.N(N), .W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_ifs (in_ifs),
    .out_if (out_if),
    .out_id (out_id),
    .locked (locked)
  );

  intf_array_rr_arbiter #(.N(1), .W(16)) dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_ifs (in1_ifs),
    .out_if (out1_if),
    .out_id (out1_id),
    .locked (locked1)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected beat: {present, id, last, data}.
  function automatic logic [11:0] beat(input logic [1:0] id, input logic l, input logic [7:0] d);
    return {1'b1, id, l, d};
  endfunction

  logic [11:0]  exp_q [$];
  logic [8:0]   srcq [N][$];
  logic [N-1:0] acc = '0;
  int unsigned  n_acc = 0, n_out = 0, n_acc1 = 0, n_locked = 0;
  logic         hold_chk = 1'b0;
  logic [7:0]   hold_data = '0;
  logic         bp_en = 1'b0;
  logic [1:0]   bp_ph = '0;
  logic [3:0]   bp_pat = 4'b1001;

  // Monitor: sample between edges; a valid&&ready seen here transfers at the next posedge.
  always @(negedge clk) begin
    logic [11:0] e;
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        acc[i] = in_valid[i] && in_ready[i];
        if (acc[i]) n_acc++;
      end
      if (acc[1]) n_acc1++;
      if (out_if.valid && out_ready) begin
        n_out++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'd0;
        check_eq("beat", {20'd0, 1'b1, out_id, out_if.last, out_if.data}, {20'd0, e});
      end
      if (hold_chk) check_eq("bp_hold", {24'd0, out_if.data}, {24'd0, hold_data});
      if (out_if.valid && !out_ready) check_eq("bp_ready", {28'd0, in_ready}, 32'd0);
      hold_chk  = out_if.valid && !out_ready;
      hold_data = out_if.data;
      if (locked) n_locked++;
    end else begin
      acc      = '0;
      hold_chk = 1'b0;
    end
  end

  // Producers: hold the queue head until accepted.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
      in_valid[i] = (srcq[i].size() > 0);
      {in_last[i], in_data[i]} = in_valid[i] ? srcq[i][0] : 9'd0;
    end
    if (bp_en) begin
      out_ready = bp_pat[bp_ph];
      bp_ph     = bp_ph + 2'd1;
    end else begin
      out_ready = 1'b1;
    end
  end

  task automatic drain(input string tag, input int max_cyc);
    for (int c = 0; c < max_cyc && exp_q.size() != 0; c++) begin
      @(negedge clk);
      #1;
    end
    check_eq(tag, exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    in_valid  = '0;
    in_last   = '0;
    out_ready = 1'b1;
    v1 = 1'b0;
    d1 = '0;
    l1 = 1'b0;
    for (int i = 0; i < N; i++) in_data[i] = '0;

    // Reset with every channel valid, then two round-robin passes.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) begin
        srcq[i].push_back({1'b1, 8'(8'h10 + i)});
        exp_q.push_back(beat(2'(i), 1'b1, 8'(8'h10 + i)));
      end
    end
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_ready", {28'd0, in_ready}, 32'd0);
    check_eq("rst_out_valid", {31'd0, out_if.valid}, 32'd0);
    check_eq("rst_out_id", {30'd0, out_id}, 32'd0);
    check_eq("rst_locked", {31'd0, locked}, 32'd0);
    check_eq("rst_n1_valid", {31'd0, out1_if.valid}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (9) @(negedge clk);
    #1;
    check_eq("rr_throughput", exp_q.size(), 0);

    // Move ptr to ch1 so ch2 is searched first, then lock on a 3-beat packet.
    srcq[1].push_back({1'b1, 8'h31});
    exp_q.push_back(beat(2'd1, 1'b1, 8'h31));
    drain("pre_lock", 10);
    n_locked = 0;
    srcq[2].push_back({1'b0, 8'hAA});
    srcq[2].push_back({1'b0, 8'hAB});
    srcq[2].push_back({1'b1, 8'hAC});
    srcq[0].push_back({1'b1, 8'h01});
    srcq[3].push_back({1'b1, 8'h03});
    exp_q.push_back(beat(2'd2, 1'b0, 8'hAA));
    exp_q.push_back(beat(2'd2, 1'b0, 8'hAB));
    exp_q.push_back(beat(2'd2, 1'b1, 8'hAC));
    exp_q.push_back(beat(2'd3, 1'b1, 8'h03));
    exp_q.push_back(beat(2'd0, 1'b1, 8'h01));
    drain("lock_drain", 20);
    check_eq("lock_cycles", n_locked, 2);

    // Backpressure with out ready pattern 1,0,0,1.
    bp_ph = '0;
    bp_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      srcq[1].push_back({1'b1, 8'(8'h20 + i)});
      exp_q.push_back(beat(2'd1, 1'b1, 8'(8'h20 + i)));
    end
    drain("bp_drain", 40);
    bp_en = 1'b0;
    @(negedge clk);
    #1;
    check_eq("acc_vs_out", n_acc, n_out);

    // Reset in the middle of a 4-beat packet from ch1.
    n_acc1 = 0;
    for (int i = 0; i < 4; i++) srcq[1].push_back({i == 3, 8'(8'h40 + i)});
    exp_q.push_back(beat(2'd1, 1'b0, 8'h40));
    for (int c = 0; c < 20 && n_acc1 < 1; c++) begin
      @(negedge clk);
      #1;
    end
    srcq[0].push_back({1'b1, 8'h55});
    for (int c = 0; c < 20 && n_acc1 < 2; c++) begin
      @(negedge clk);
      #1;
    end
    check_eq("mid_acc", n_acc1, 2);
    @(posedge clk);
    #2;
    check_eq("mid_locked_pre", {31'd0, locked}, 32'd1);
    rst_n = 1'b0;
    srcq[1].delete();
    #1;
    check_eq("mid_locked_clr", {31'd0, locked}, 32'd0);
    check_eq("mid_valid_clr", {31'd0, out_if.valid}, 32'd0);
    check_eq("mid_ready_clr", {28'd0, in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    exp_q.push_back(beat(2'd0, 1'b1, 8'h55));
    drain("mid_recover", 10);

    // N=1, W=16 instance.
    @(negedge clk);
    v1 = 1'b1;
    d1 = 16'h1234;
    l1 = 1'b0;
    #1;
    check_eq("n1_ready", {31'd0, in1_ifs[0].ready}, 32'd1);
    @(negedge clk);
    check_eq("n1_b0_valid", {31'd0, out1_if.valid}, 32'd1);
    check_eq("n1_b0_data", {16'd0, out1_if.data}, 32'h1234);
    check_eq("n1_b0_last", {31'd0, out1_if.last}, 32'd0);
    check_eq("n1_b0_id", {31'd0, out1_id}, 32'd0);
    check_eq("n1_b0_locked", {31'd0, locked1}, 32'd1);
    d1 = 16'h5678;
    l1 = 1'b1;
    @(negedge clk);
    check_eq("n1_b1_data", {16'd0, out1_if.data}, 32'h5678);
    check_eq("n1_b1_last", {31'd0, out1_if.last}, 32'd1);
    check_eq("n1_b1_locked", {31'd0, locked1}, 32'd0);
    v1 = 1'b0;
    @(negedge clk);
    check_eq("n1_idle_valid", {31'd0, out1_if.valid}, 32'd0);
    check_eq("n1_idle_locked", {31'd0, locked1}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
